// File: rtl/jt49_dcrm_pkg.sv
// Shared constants for the time-multiplexed DC-removal scheduler: FSM encoding,
// default widths and channel indices.
package jt49_dcrm_pkg;

  localparam int DCRM_DW    = 8;
  localparam int DCRM_SHIFT = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CH_A = 2'd1;
  localparam logic [1:0] ST_CH_B = 2'd2;
  localparam logic [1:0] ST_CH_C = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CH_A = ST_CH_A,
    CH_B = ST_CH_B,
    CH_C = ST_CH_C
  } state_t;

  localparam int NCH = 3;
  localparam logic [1:0] CH_IDX_A = 2'd0;
  localparam logic [1:0] CH_IDX_B = 2'd1;
  localparam logic [1:0] CH_IDX_C = 2'd2;

endpackage

// File: rtl/jt49_dcrm_core.sv
// Combinational single-channel leaky-integrator step. Output formatting is
// half gain by default, saturated full gain when JT49_DCRM_SAT_EN is defined.
module jt49_dcrm_core
  import jt49_dcrm_pkg::*;
#(
  parameter int DW    = DCRM_DW,
  parameter int SHIFT = DCRM_SHIFT,
  localparam int ACCW = DW + SHIFT
) (
  input  logic [ACCW-1:0] acc_i,
  input  logic [DW-1:0]   din_i,
  input  logic            first_i,
  output logic [ACCW-1:0] acc_next_o,
  output logic [7:0]      dout_o
);

  logic [DW-1:0]      avg;
  logic signed [DW:0] diff;

  assign avg = acc_i[ACCW-1:SHIFT];

  // acc >= avg << SHIFT >= avg, so acc + din - avg never leaves [0, 2^ACCW-1].
  assign acc_next_o = first_i ? {din_i, {SHIFT{1'b0}}}
                              : acc_i + ACCW'(din_i) - ACCW'(avg);

  assign diff = first_i ? '0 : $signed({1'b0, din_i}) - $signed({1'b0, avg});

`ifdef JT49_DCRM_SAT_EN
  localparam logic signed [DW:0] POS_LIM = (DW+1)'(127);
  localparam logic signed [DW:0] NEG_LIM = (DW+1)'(-128);

  always_comb begin
    if (diff > POS_LIM) begin
      dout_o = 8'h7f;
    end else if (diff < NEG_LIM) begin
      dout_o = 8'h80;
    end else begin
      dout_o = diff[7:0];
    end
  end
`else
  logic [DW-8:0] diff_lsb_unused;

  assign dout_o          = diff[DW -: 8];
  assign diff_lsb_unused = diff[DW-8:0];
`endif

endmodule

// File: rtl/jt49_dcrm_sched.sv
// Round-robin DC-removal scheduler for PSG channels A/B/C sharing one
// jt49_dcrm_core; output gain is selected by JT49_DCRM_SAT_EN in the core.
module jt49_dcrm_sched
  import jt49_dcrm_pkg::*;
#(
  parameter int DW    = DCRM_DW,
  parameter int SHIFT = DCRM_SHIFT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  output logic [7:0]    dout_a,
  output logic [7:0]    dout_b,
  output logic [7:0]    dout_c,
  output logic          dout_valid,
  output logic          busy,
  output logic          ovr
);

  localparam int ACCW = DW + SHIFT;

  state_t           state_q;
  logic [DW-1:0]    snap_q [NCH];
  logic [ACCW-1:0]  acc_q  [NCH];
  logic [7:0]       dout_q [NCH];
  logic [NCH-1:0]   first_q;
  logic             valid_q;
  logic             busy_q;
  logic             ovr_q;

  logic [1:0]       ch_sel;
  logic [ACCW-1:0]  core_acc;
  logic [DW-1:0]    core_din;
  logic             core_first;
  logic [ACCW-1:0]  core_acc_d;
  logic [7:0]       core_dout_d;

  always_comb begin
    ch_sel = CH_IDX_A;
    case (state_q)
      CH_B:    ch_sel = CH_IDX_B;
      CH_C:    ch_sel = CH_IDX_C;
      default: ch_sel = CH_IDX_A;
    endcase
  end

  always_comb begin
    core_acc   = acc_q[CH_IDX_A];
    core_din   = snap_q[CH_IDX_A];
    core_first = first_q[CH_IDX_A];
    case (state_q)
      CH_B: begin
        core_acc   = acc_q[CH_IDX_B];
        core_din   = snap_q[CH_IDX_B];
        core_first = first_q[CH_IDX_B];
      end
      CH_C: begin
        core_acc   = acc_q[CH_IDX_C];
        core_din   = snap_q[CH_IDX_C];
        core_first = first_q[CH_IDX_C];
      end
      default: ;
    endcase
  end

  jt49_dcrm_core #(
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_core (
    .acc_i      (core_acc),
    .din_i      (core_din),
    .first_i    (core_first),
    .acc_next_o (core_acc_d),
    .dout_o     (core_dout_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      first_q <= '1;
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= '0;
        acc_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      ovr_q   <= cen && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (cen) begin
            snap_q[CH_IDX_A] <= din_a;
            snap_q[CH_IDX_B] <= din_b;
            snap_q[CH_IDX_C] <= din_c;
            state_q          <= CH_A;
            busy_q           <= 1'b1;
          end
        end
        CH_A, CH_B, CH_C: begin
          acc_q[ch_sel]   <= core_acc_d;
          dout_q[ch_sel]  <= core_dout_d;
          first_q[ch_sel] <= 1'b0;
          if (state_q == CH_A) begin
            state_q <= CH_B;
          end else if (state_q == CH_B) begin
            state_q <= CH_C;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_a     = dout_q[CH_IDX_A];
  assign dout_b     = dout_q[CH_IDX_B];
  assign dout_c     = dout_q[CH_IDX_C];
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign ovr        = ovr_q;

endmodule
